// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO tag insertion path.
// Holds the info-word geometry, base tuser width and the inserter FSM encoding.
// Info words are carried opaquely; the field offsets exist for the scheduler side.
package pifo_pkg;

  // Width of the per-packet info word and of the standard SUME metadata
  localparam int PIFO_INFO_BITS  = 32;
  localparam int BASE_TUSER_BITS = 128;

  // Field layout of the info word as the scheduler interprets it
  localparam int INFO_VALID_BIT  = 31;
  localparam int INFO_RANK_MSB   = 30;
  localparam int INFO_RANK_LSB   = 15;
  localparam int INFO_FIELD_MSB  = 14;
  localparam int INFO_FIELD_LSB  = 0;

  // Packet-position state of the inserter
  typedef enum logic {
    ST_SOP = 1'b0,
    ST_MID = 1'b1
  } fsm_state_t;

  // Extracts the rank field, for consumers that decode the info word
  function automatic logic [INFO_RANK_MSB-INFO_RANK_LSB:0] info_rank(
    input logic [PIFO_INFO_BITS-1:0] info
  );
    return info[INFO_RANK_MSB:INFO_RANK_LSB];
  endfunction

endpackage

// File: rtl/pifo_info_fifo.sv
// Synchronous FIFO holding per-packet info words until their packet starts.
// Latency: a pushed word appears at head the cycle after the push (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; flags are registered state.
module pifo_info_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pifo_tag_inserter.sv
// Merges the per-packet PIFO info word into tuser[159:128] of every beat of its packet.
// Latency: 1 cycle from accepted input beat to m_axis_tvalid; 1 beat/cycle sustained.
// Backpressure: SOP beats stall until info is queued; a registered 2-entry skid keeps tready off m_axis_tready.
module pifo_tag_inserter
  import pifo_pkg::*;
#(
  parameter int DATA_WIDTH           = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = BASE_TUSER_BITS,
  parameter int C_M_AXIS_TUSER_WIDTH = BASE_TUSER_BITS + PIFO_INFO_BITS,
  parameter int PIFO_INFO_LENGTH     = PIFO_INFO_BITS,
  parameter int INFO_FIFO_DEPTH_BITS = 2,
  parameter int C_S_AXI_DATA_WIDTH   = 32
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]         s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  input  logic [PIFO_INFO_LENGTH-1:0]     s_pifo_info_tdata,
  input  logic                            s_pifo_info_tvalid,
  output logic                            s_pifo_info_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]         m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   pkt_tagged,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   info_stall_cycles
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]           tdata;
    logic [DATA_WIDTH/8-1:0]         tkeep;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser;
    logic                            tlast;
  } beat_t;

  localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE = 1;

  fsm_state_t                  state;
  logic [PIFO_INFO_LENGTH-1:0] cur_info;
  logic [PIFO_INFO_LENGTH-1:0] fifo_head;
  logic [PIFO_INFO_LENGTH-1:0] beat_info;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        info_push;

  beat_t                       skid [2];
  beat_t                       in_beat;
  logic                        skid_rd;
  logic                        skid_wr;
  logic [1:0]                  skid_cnt;
  logic [1:0]                  skid_cnt_nxt;
  logic                        skid_has_space;

  logic                        in_rdy;
  logic                        in_fire;
  logic                        sop_fire;
  logic                        out_vld;
  logic                        out_fire;

  pifo_info_fifo #(
    .WIDTH      (PIFO_INFO_LENGTH),
    .DEPTH_BITS (INFO_FIFO_DEPTH_BITS)
  ) u_info_fifo (
    .clk       (axis_aclk),
    .rst_n     (axis_resetn),
    .push      (info_push),
    .push_data (s_pifo_info_tdata),
    .pop       (sop_fire),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Input acceptance, tag selection and skid occupancy update
  always_comb begin
    info_push     = s_pifo_info_tvalid && axis_resetn && !fifo_full;
    in_rdy        = axis_resetn && skid_has_space && ((state == ST_MID) || !fifo_empty);
    in_fire       = s_axis_tvalid && in_rdy;
    sop_fire      = in_fire && (state == ST_SOP);
    beat_info     = (state == ST_SOP) ? fifo_head : cur_info;
    in_beat.tdata = s_axis_tdata;
    in_beat.tkeep = s_axis_tkeep;
    in_beat.tuser = {beat_info, s_axis_tuser};
    in_beat.tlast = s_axis_tlast;
    out_vld       = (skid_cnt != 2'd0);
    out_fire      = out_vld && m_axis_tready;
    unique case ({in_fire, out_fire})
      2'b10:   skid_cnt_nxt = skid_cnt + 2'd1;
      2'b01:   skid_cnt_nxt = skid_cnt - 2'd1;
      default: skid_cnt_nxt = skid_cnt;
    endcase
  end

  assign s_axis_tready      = in_rdy;
  assign s_pifo_info_tready = axis_resetn && !fifo_full;
  assign m_axis_tvalid      = out_vld;
  assign m_axis_tdata       = skid[skid_rd].tdata;
  assign m_axis_tkeep       = skid[skid_rd].tkeep;
  assign m_axis_tuser       = skid[skid_rd].tuser;
  assign m_axis_tlast       = skid[skid_rd].tlast;

  // Packet-position FSM; latches the SOP info so later beats of the packet reuse it
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state    <= ST_SOP;
      cur_info <= '0;
    end else begin
      unique case (state)
        ST_SOP: if (in_fire) begin
          cur_info <= fifo_head;
          state    <= s_axis_tlast ? ST_SOP : ST_MID;
        end
        ST_MID: if (in_fire && s_axis_tlast) state <= ST_SOP;
        default: state <= ST_SOP;
      endcase
    end
  end

  // Two-entry output skid; space flag is registered from next occupancy so ready has no path from m_axis_tready
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      skid[0]        <= '0;
      skid[1]        <= '0;
      skid_rd        <= 1'b0;
      skid_wr        <= 1'b0;
      skid_cnt       <= 2'd0;
      skid_has_space <= 1'b1;
    end else begin
      if (in_fire) begin
        skid[skid_wr] <= in_beat;
        skid_wr       <= ~skid_wr;
      end
      if (out_fire) skid_rd <= ~skid_rd;
      skid_cnt       <= skid_cnt_nxt;
      skid_has_space <= (skid_cnt_nxt != 2'd2);
    end
  end

  // Statistics: packets leaving and SOP cycles blocked on missing info, both wrapping
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      pkt_tagged        <= '0;
      info_stall_cycles <= '0;
    end else begin
      if (out_fire && m_axis_tlast) pkt_tagged <= pkt_tagged + CNT_ONE;
      if ((state == ST_SOP) && s_axis_tvalid && fifo_empty)
        info_stall_cycles <= info_stall_cycles + CNT_ONE;
    end
  end

endmodule
